bilateral3x3_pipe: RTL

- Parametrised, fully pipelined successor to the fixed 8-bit 3x3 bilateral filter on the streaming grayscale path.
- Accepts one pixel per `in_valid` cycle in raster order and keeps two line buffers.
- Computes an edge-preserving weighted average using a fixed 1-2-1 spatial kernel and a runtime-selectable range falloff.
- Emits only interior pixels, with exact centre coordinates, a frame-end marker and a per-frame bypass mode.

---
 rtl/bilateral3x3_pipe_if.sv | 28 ++
 rtl/bilateral3x3_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bilateral3x3_pipe_if.sv
// Streaming bundle for the 3x3 bilateral filter: raster pixel input with frame
// controls, and the filtered pixel output with its centre coordinates.
interface bilateral3x3_pipe_if #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned ROW_W = 8,
  parameter int unsigned COL_W = 9
);
  logic             in_valid;
  logic [PIX_W-1:0] in_pix;
  logic             in_sof;
  logic [1:0]       range_shift;
  logic             bypass;
  logic             out_valid;
  logic [PIX_W-1:0] out_pix;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_eof;

  modport master (
    output in_valid, in_pix, in_sof, range_shift, bypass,
    input  out_valid, out_pix, out_row, out_col, out_eof
  );

  modport slave (
    input  in_valid, in_pix, in_sof, range_shift, bypass,
    output out_valid, out_pix, out_row, out_col, out_eof
  );
endinterface

// File: rtl/bilateral3x3_pipe.sv
// Fully pipelined 3x3 bilateral filter: two line buffers, 1-2-1 spatial kernel,
// selectable range falloff, restoring divider with one quotient bit per stage.
module bilateral3x3_pipe #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned PIX_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  bilateral3x3_pipe_if.slave bus
);
  localparam int unsigned ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int unsigned COL_W  = $clog2(IMAGE_WIDTH);
  localparam int unsigned SUMW_W = 13;
  localparam int unsigned SUMN_W = PIX_W + 13;
  localparam logic [ROW_W-1:0] RowLast = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] ColLast = COL_W'(IMAGE_WIDTH - 1);

  typedef logic [PIX_W-1:0] pix_t;
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             eof;
    logic             byp;
  } meta_t;

  function automatic int unsigned sp_shift(input int unsigned i);
    if (i == 4) return 2;
    if (i == 1 || i == 3 || i == 5 || i == 7) return 1;
    return 0;
  endfunction

  // ---------------- S0: input counters and line buffers ----------------
  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [1:0]       rs_q, cur_rs;
  logic             byp_q, cur_byp;
  pix_t             lb0 [IMAGE_WIDTH];
  pix_t             lb1 [IMAGE_WIDTH];

  logic  s0_valid, s0_ok;
  pix_t  s0_top, s0_mid, s0_bot;
  logic [1:0] s0_rs;
  meta_t s0_meta;

  // sof forces the accepted pixel to (0,0) and supplies the frame's controls
  always_comb begin
    cur_col = bus.in_sof ? '0 : col_q;
    cur_row = bus.in_sof ? '0 : row_q;
    cur_rs  = bus.in_sof ? bus.range_shift : rs_q;
    cur_byp = bus.in_sof ? bus.bypass : byp_q;
    col_d   = cur_col + 1'b1;
    row_d   = cur_row;
    if (cur_col == ColLast) begin
      col_d = '0;
      row_d = (cur_row == RowLast) ? '0 : cur_row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb0[cur_col] <= bus.in_pix;
      lb1[cur_col] <= lb0[cur_col];
      s0_top       <= lb1[cur_col];
      s0_mid       <= lb0[cur_col];
      s0_bot       <= bus.in_pix;
      s0_ok        <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
      s0_rs        <= cur_rs;
      s0_meta.row  <= cur_row - 1'b1;
      s0_meta.col  <= cur_col - 1'b1;
      s0_meta.eof  <= (cur_row == RowLast) && (cur_col == ColLast);
      s0_meta.byp  <= cur_byp;
    end
  end

  // ---------------- S1: 3x3 window, row-major, centre at index 4 ----------------
  pix_t       win_q [9];
  logic       s1_valid;
  logic [1:0] s1_rs;
  meta_t      s1_meta;

  always_ff @(posedge clk) begin
    if (s0_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r*3]   <= win_q[r*3+1];
        win_q[r*3+1] <= win_q[r*3+2];
      end
      win_q[2] <= s0_top;
      win_q[5] <= s0_mid;
      win_q[8] <= s0_bot;
      s1_rs    <= s0_rs;
      s1_meta  <= s0_meta;
    end
  end

  // ---------------- S2: range weights ----------------
  logic [8:0]  rw_c [9];
  pix_t        absd;
  logic [7:0]  absd8;
  logic [10:0] scaled;

  always_comb begin
    absd   = '0;
    absd8  = '0;
    scaled = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      absd    = (win_q[i] > win_q[4]) ? win_q[i] - win_q[4] : win_q[4] - win_q[i];
      absd8   = 8'(absd >> (PIX_W - 8));
      scaled  = 11'(absd8) << s1_rs;
      rw_c[i] = (scaled >= 11'd256) ? 9'd0 : 9'(11'd256 - scaled);
    end
  end

  logic [8:0] s2_rw  [9];
  pix_t       s2_pix [9];
  logic       s2_valid;
  meta_t      s2_meta;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 9; i++) begin
      s2_rw[i]  <= rw_c[i];
      s2_pix[i] <= win_q[i];
    end
    s2_meta <= s1_meta;
  end

  // ---------------- S3: weighted sums, rounding bias folded into numerator ----------------
  logic [SUMW_W-1:0] sum_w;
  logic [SUMN_W-1:0] sum_n, num_c;

  always_comb begin
    sum_w = '0;
    sum_n = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      sum_w = sum_w + (SUMW_W'(s2_rw[i]) << sp_shift(i));
      sum_n = sum_n + ((SUMN_W'(s2_rw[i]) * SUMN_W'(s2_pix[i])) << sp_shift(i));
    end
    num_c = sum_n + SUMN_W'(sum_w >> 1);
  end

  // ---------------- S3 + divider: index 0 is S3, index k+1 has quotient bit k resolved ----------------
  logic              st_valid [PIX_W+1];
  logic [SUMN_W-1:0] st_num   [PIX_W+1];
  logic [SUMW_W-1:0] st_den   [PIX_W+1];
  pix_t              st_quo   [PIX_W+1];
  pix_t              st_ctr   [PIX_W+1];
  meta_t             st_meta  [PIX_W+1];
  logic [SUMN_W-1:0] trial    [PIX_W];
  pix_t              qbit     [PIX_W];

  always_comb begin
    for (int unsigned k = 0; k < PIX_W; k++) begin
      trial[k] = SUMN_W'(st_den[k]) << (PIX_W - 1 - k);
      qbit[k]  = pix_t'(1) << (PIX_W - 1 - k);
    end
  end

  always_ff @(posedge clk) begin
    st_num[0]  <= num_c;
    st_den[0]  <= sum_w;
    st_quo[0]  <= '0;
    st_ctr[0]  <= s2_pix[4];
    st_meta[0] <= s2_meta;
    for (int unsigned k = 0; k < PIX_W; k++) begin
      st_den[k+1]  <= st_den[k];
      st_ctr[k+1]  <= st_ctr[k];
      st_meta[k+1] <= st_meta[k];
      if (st_num[k] >= trial[k]) begin
        st_num[k+1] <= st_num[k] - trial[k];
        st_quo[k+1] <= st_quo[k] | qbit[k];
      end else begin
        st_num[k+1] <= st_num[k];
        st_quo[k+1] <= st_quo[k];
      end
    end
  end

  // ---------------- Output ----------------
  logic  out_valid_q, out_eof_q;
  pix_t  out_pix_q, res_pix;
  logic [ROW_W-1:0] out_row_q;
  logic [COL_W-1:0] out_col_q;
  logic  sat;

  // A remainder still >= divisor means the quotient overflowed PIX_W bits
  always_comb begin
    sat     = st_num[PIX_W] >= SUMN_W'(st_den[PIX_W]);
    res_pix = sat ? '1 : st_quo[PIX_W];
    if (st_meta[PIX_W].byp) res_pix = st_ctr[PIX_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      rs_q        <= '0;
      byp_q       <= 1'b0;
      s0_valid    <= 1'b0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      for (int unsigned k = 0; k <= PIX_W; k++) st_valid[k] <= 1'b0;
      out_valid_q <= 1'b0;
      out_eof_q   <= 1'b0;
      out_pix_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      if (bus.in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        rs_q  <= cur_rs;
        byp_q <= cur_byp;
      end
      s0_valid    <= bus.in_valid;
      s1_valid    <= s0_valid && s0_ok;
      s2_valid    <= s1_valid;
      st_valid[0] <= s2_valid;
      for (int unsigned k = 0; k < PIX_W; k++) st_valid[k+1] <= st_valid[k];
      out_valid_q <= st_valid[PIX_W];
      out_eof_q   <= st_valid[PIX_W] && st_meta[PIX_W].eof;
      if (st_valid[PIX_W]) begin
        out_pix_q <= res_pix;
        out_row_q <= st_meta[PIX_W].row;
        out_col_q <= st_meta[PIX_W].col;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.out_pix   = out_pix_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;

endmodule
